// File: rtl/l2_request_scheduler.sv
// Round-robin scheduler sharing the L2 memory request channel among NUM_PORTS requesters.
// Define L2_SCHED_FIXED_PRIORITY_EN to grant the lowest-index valid port instead.
module l2_request_scheduler #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned SUB_ID_W  = 2,
    parameter int unsigned PORT_W    = $clog2(NUM_PORTS),
    parameter int unsigned ID_W      = PORT_W + SUB_ID_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               req_valid,
    output logic [NUM_PORTS-1:0]               req_ready,
    input  logic [NUM_PORTS-1:0][29:0]         req_addr,
    input  logic [NUM_PORTS-1:0]               req_rnw,
    input  logic [NUM_PORTS-1:0]               req_is_amo,
    input  logic [NUM_PORTS-1:0][4:0]          req_size,
    input  logic [NUM_PORTS-1:0][SUB_ID_W-1:0] req_sub_id,
    input  logic [NUM_PORTS-1:0]               wdata_valid,
    output logic [NUM_PORTS-1:0]               wdata_ready,
    input  logic [NUM_PORTS-1:0][31:0]         wdata,
    input  logic [NUM_PORTS-1:0][3:0]          wbe,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [29:0]                        mem_addr,
    output logic                               mem_rnw,
    output logic                               mem_is_amo,
    output logic [4:0]                         mem_size,
    output logic [ID_W-1:0]                    mem_id,
    output logic                               mem_wdata_valid,
    input  logic                               mem_wdata_ready,
    output logic [31:0]                        mem_wdata,
    output logic [3:0]                         mem_wbe,
    output logic                               attr_push,
    input  logic                               attr_full,
    output logic [PORT_W-1:0]                  attr_id,
    output logic [4:0]                         attr_burst,
    output logic                               busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWdata} state_e;

    state_e                state_q, state_d;
    logic [PORT_W-1:0]     grant_q, grant_d;
    logic [29:0]           addr_q, addr_d;
    logic                  rnw_q, rnw_d;
    logic                  is_amo_q, is_amo_d;
    logic [4:0]            size_q, size_d;
    logic [SUB_ID_W-1:0]   sub_id_q, sub_id_d;
    logic [4:0]            beat_cnt_q, beat_cnt_d;
    logic                  found;
    logic [PORT_W-1:0]     grant_sel;
    logic                  needs_attr;

`ifdef L2_SCHED_FIXED_PRIORITY_EN
    always_comb begin
        found     = 1'b0;
        grant_sel = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found     = 1'b1;
                grant_sel = PORT_W'(i);
            end
        end
    end
`else
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        found     = 1'b0;
        grant_sel = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            int unsigned idx;
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_sel = PORT_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == StIdle && found) begin
            rr_ptr_d = (grant_sel == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_sel + PORT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign needs_attr = rnw_q | is_amo_q;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        addr_d          = addr_q;
        rnw_d           = rnw_q;
        is_amo_d        = is_amo_q;
        size_d          = size_q;
        sub_id_d        = sub_id_q;
        beat_cnt_d      = beat_cnt_q;
        req_ready       = '0;
        wdata_ready     = '0;
        mem_req_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        mem_wbe         = '0;
        attr_push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    // Gated by reset so an asserted reset never reports a capture.
                    req_ready[grant_sel] = rst_n;
                    grant_d  = grant_sel;
                    addr_d   = req_addr[grant_sel];
                    rnw_d    = req_rnw[grant_sel];
                    is_amo_d = req_is_amo[grant_sel];
                    size_d   = req_size[grant_sel];
                    sub_id_d = req_sub_id[grant_sel];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                mem_req_valid = !(attr_full && needs_attr);
                if (mem_req_valid && mem_req_ready) begin
                    attr_push = needs_attr;
                    if (rnw_q) begin
                        state_d = StIdle;
                    end else begin
                        beat_cnt_d = is_amo_q ? 5'd0 : size_q;
                        state_d    = StWdata;
                    end
                end
            end
            StWdata: begin
                mem_wdata_valid      = wdata_valid[grant_q];
                wdata_ready[grant_q] = mem_wdata_ready;
                mem_wdata            = wdata[grant_q];
                mem_wbe              = wbe[grant_q];
                if (wdata_valid[grant_q] && mem_wdata_ready) begin
                    if (beat_cnt_q == 5'd0) state_d = StIdle;
                    else                    beat_cnt_d = beat_cnt_q - 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            is_amo_q   <= 1'b0;
            size_q     <= '0;
            sub_id_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            rnw_q      <= rnw_d;
            is_amo_q   <= is_amo_d;
            size_q     <= size_d;
            sub_id_q   <= sub_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_rnw    = rnw_q;
    assign mem_is_amo = is_amo_q;
    assign mem_size   = size_q;
    assign mem_id     = {grant_q, sub_id_q};
    assign attr_id    = grant_q;
    assign attr_burst = is_amo_q ? 5'd0 : size_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_l2_request_scheduler.sv
// Directed bench for l2_request_scheduler: a 2-port instance for the main scenarios and a
// 3-port instance for the grant-order sequence.
module tb_l2_request_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [1:0]       req_valid, req_ready, req_rnw, req_is_amo, wdata_valid, wdata_ready;
    logic [1:0][29:0] req_addr;
    logic [1:0][4:0]  req_size;
    logic [1:0][1:0]  req_sub_id;
    logic [1:0][31:0] wdata;
    logic [1:0][3:0]  wbe;
    logic             mem_req_valid, mem_req_ready, mem_rnw, mem_is_amo;
    logic [29:0]      mem_addr;
    logic [4:0]       mem_size, attr_burst;
    logic [2:0]       mem_id;
    logic             mem_wdata_valid, mem_wdata_ready, attr_push, attr_full, busy;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wbe;
    logic [0:0]       attr_id;

    l2_request_scheduler #(.NUM_PORTS(2), .SUB_ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rnw(req_rnw), .req_is_amo(req_is_amo), .req_size(req_size),
        .req_sub_id(req_sub_id), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata(wdata), .wbe(wbe), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_rnw(mem_rnw),
        .mem_is_amo(mem_is_amo), .mem_size(mem_size), .mem_id(mem_id),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_wbe(mem_wbe), .attr_push(attr_push),
        .attr_full(attr_full), .attr_id(attr_id), .attr_burst(attr_burst), .busy(busy)
    );

    logic [2:0]       req_valid3, req_ready3, wdata_ready3;
    logic             mem_req_valid3, mem_rnw3, mem_is_amo3, mem_wdata_valid3, attr_push3, busy3;
    logic [29:0]      mem_addr3;
    logic [4:0]       mem_size3, attr_burst3;
    logic [3:0]       mem_id3;
    logic [31:0]      mem_wdata3;
    logic [3:0]       mem_wbe3;
    logic [1:0]       attr_id3;

    l2_request_scheduler #(.NUM_PORTS(3), .SUB_ID_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr('0),
        .req_rnw(3'b111), .req_is_amo(3'b000), .req_size('0),
        .req_sub_id('0), .wdata_valid(3'b000), .wdata_ready(wdata_ready3),
        .wdata('0), .wbe('0), .mem_req_valid(mem_req_valid3),
        .mem_req_ready(1'b1), .mem_addr(mem_addr3), .mem_rnw(mem_rnw3),
        .mem_is_amo(mem_is_amo3), .mem_size(mem_size3), .mem_id(mem_id3),
        .mem_wdata_valid(mem_wdata_valid3), .mem_wdata_ready(1'b1),
        .mem_wdata(mem_wdata3), .mem_wbe(mem_wbe3), .attr_push(attr_push3),
        .attr_full(1'b0), .attr_id(attr_id3), .attr_burst(attr_burst3), .busy(busy3)
    );

    // Every step lands 1 time unit after a rising edge; checks follow a further #1.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = '0; req_addr = '0; req_rnw = '0; req_is_amo = '0; req_size = '0;
        req_sub_id = '0; wdata_valid = '0; wdata = '0; wbe = '0;
        mem_req_ready = 1'b1; mem_wdata_ready = 1'b1; attr_full = 1'b0; req_valid3 = '0;
        rst_n = 1'b0;
        adv(); adv();
        #1;
        total++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b mrv=%b rdy=%b need 0/0/00",
                     busy, mem_req_valid, req_ready);
        end
        total++;
        if (mem_id !== 3'b000 || mem_addr !== 30'h0 || attr_push !== 1'b0) begin
            bad++;
            $display("FAIL reset_fields got id=%b addr=%h push=%b need 000/0/0",
                     mem_id, mem_addr, attr_push);
        end
        adv();
        rst_n = 1'b1;
    endtask

    task automatic test_two_reads();
        adv();
        req_valid = 2'b11; req_rnw = 2'b11;
        req_addr[0] = 30'h100; req_addr[1] = 30'h200;
        req_size[0] = 5'd2; req_size[1] = 5'd0;
        req_sub_id[0] = 2'd1; req_sub_id[1] = 2'd1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL rr_first_grant got=%b need=01", req_ready);
        end
        adv();
        req_valid = 2'b10;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_id !== 3'b001 || mem_addr !== 30'h100) begin
            bad++;
            $display("FAIL issue_p0 got v=%b id=%b addr=%h need 1/001/100",
                     mem_req_valid, mem_id, mem_addr);
        end
        total++;
        if (attr_push !== 1'b1 || attr_id !== 1'b0 || attr_burst !== 5'd2) begin
            bad++;
            $display("FAIL attr_p0 got push=%b id=%b burst=%0d need 1/0/2",
                     attr_push, attr_id, attr_burst);
        end
        adv();
        #1;
        total++;
        if (req_ready !== 2'b10 || busy !== 1'b0) begin
            bad++; $display("FAIL second_grant got rdy=%b busy=%b need 10/0", req_ready, busy);
        end
        adv();
        req_valid = 2'b00;
        #1;
        total++;
        if (mem_id !== 3'b101 || attr_id !== 1'b1 || attr_burst !== 5'd0
            || mem_addr !== 30'h200) begin
            bad++;
            $display("FAIL issue_p1 got id=%b aid=%b burst=%0d addr=%h need 101/1/0/200",
                     mem_id, attr_id, attr_burst, mem_addr);
        end
        adv();
    endtask

    task automatic test_write_burst();
        req_valid = 2'b10; req_rnw = 2'b01; req_size[1] = 5'd3; req_sub_id[1] = 2'd2;
        req_addr[1] = 30'h300;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++; $display("FAIL wr_grant got=%b need=10", req_ready);
        end
        adv();
        req_valid = 2'b01; req_rnw = 2'b01; req_size[0] = 5'd1; req_sub_id[0] = 2'd3;
        req_addr[0] = 30'h040;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_rnw !== 1'b0 || mem_size !== 5'd3
            || mem_id !== 3'b110 || attr_push !== 1'b0 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL wr_issue got v=%b rnw=%b sz=%0d id=%b push=%b rdy=%b",
                     mem_req_valid, mem_rnw, mem_size, mem_id, attr_push, req_ready);
        end
        adv();
        for (int b = 0; b < 4; b++) begin
            wdata_valid = 2'b11;
            wdata[1] = 32'hA000_0000 + 32'(b); wbe[1] = 4'(b + 1);
            wdata[0] = 32'hDEAD_BEEF; wbe[0] = 4'hF;
            #1;
            total++;
            if (mem_wdata_valid !== 1'b1 || mem_wdata !== 32'hA000_0000 + 32'(b)
                || mem_wbe !== 4'(b + 1) || wdata_ready !== 2'b10 || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL wr_beat%0d got v=%b d=%h be=%h wr=%b rr=%b", b,
                         mem_wdata_valid, mem_wdata, mem_wbe, wdata_ready, req_ready);
            end
            adv();
        end
        wdata_valid = 2'b00;
        #1;
        total++;
        if (req_ready !== 2'b01 || busy !== 1'b0) begin
            bad++; $display("FAIL after_burst got rdy=%b busy=%b need 01/0", req_ready, busy);
        end
        adv();
        req_valid = 2'b00;
        #1;
        total++;
        if (mem_id !== 3'b011 || mem_rnw !== 1'b1 || attr_burst !== 5'd1) begin
            bad++;
            $display("FAIL waited_read got id=%b rnw=%b burst=%0d need 011/1/1",
                     mem_id, mem_rnw, attr_burst);
        end
        adv();
    endtask

    task automatic test_stall();
        req_valid = 2'b01; req_rnw = 2'b11; req_addr[0] = 30'h1234; req_sub_id[0] = 2'd2;
        req_size[0] = 5'd0; mem_req_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL stall_grant got=%b need=01", req_ready);
        end
        adv();
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (mem_req_valid !== 1'b1 || attr_push !== 1'b0 || mem_addr !== 30'h1234
                || mem_id !== 3'b010 || mem_size !== 5'd0) begin
                bad++;
                $display("FAIL stall_hold%0d got v=%b push=%b addr=%h id=%b sz=%0d", i,
                         mem_req_valid, attr_push, mem_addr, mem_id, mem_size);
            end
            adv();
        end
        mem_req_ready = 1'b1;
        #1;
        total++;
        if (attr_push !== 1'b1 || mem_addr !== 30'h1234) begin
            bad++; $display("FAIL stall_accept got push=%b addr=%h need 1/1234", attr_push, mem_addr);
        end
        adv();
        #1;
        total++;
        if (attr_push !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL stall_done got push=%b busy=%b need 0/0", attr_push, busy);
        end
    endtask

    task automatic test_attr_full();
        attr_full = 1'b1;
        req_valid = 2'b10; req_rnw = 2'b11; req_size[1] = 5'd4; req_sub_id[1] = 2'd0;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++; $display("FAIL af_grant got=%b need=10", req_ready);
        end
        adv();
        req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (mem_req_valid !== 1'b0 || attr_push !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL af_blocked%0d got v=%b push=%b busy=%b need 0/0/1", i,
                         mem_req_valid, attr_push, busy);
            end
            adv();
        end
        attr_full = 1'b0;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || attr_push !== 1'b1 || attr_burst !== 5'd4
            || attr_id !== 1'b1) begin
            bad++;
            $display("FAIL af_release got v=%b push=%b burst=%0d id=%b need 1/1/4/1",
                     mem_req_valid, attr_push, attr_burst, attr_id);
        end
        adv();
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 2'b01; req_rnw = 2'b00; req_size[0] = 5'd3; req_sub_id[0] = 2'd1;
        req_addr[0] = 30'h0AB;
        adv();
        req_valid = 2'b00;
        adv();
        wdata_valid = 2'b01; wdata[0] = 32'h1111_2222; wbe[0] = 4'h3;
        adv();
        #1;
        total++;
        if (mem_wdata_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL pre_reset_beat got v=%b busy=%b need 1/1", mem_wdata_valid, busy);
        end
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        total++;
        if (mem_wdata_valid !== 1'b0 || wdata_ready !== 2'b00 || busy !== 1'b0
            || mem_wdata !== 32'h0 || req_ready !== 2'b00) begin
            bad++;
            $display("FAIL async_reset got v=%b wr=%b busy=%b d=%h rr=%b",
                     mem_wdata_valid, wdata_ready, busy, mem_wdata, req_ready);
        end
        total++;
        if (mem_addr !== 30'h0 || mem_id !== 3'b000 || mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_fields got addr=%h id=%b v=%b need 0/000/0",
                     mem_addr, mem_id, mem_req_valid);
        end
        wdata_valid = 2'b00;
        adv();
        rst_n = 1'b1; req_rnw = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL post_reset_grant got=%b need=01", req_ready);
        end
        adv();
        req_valid = 2'b00;
        #1;
        total++;
        if (mem_id !== 3'b001) begin
            bad++; $display("FAIL post_reset_id got=%b need=001", mem_id);
        end
        adv();
    endtask

    task automatic test_three_ports();
        logic [1:0] exp;
        req_valid3 = 3'b111;
        for (int k = 0; k < 6; k++) begin
`ifdef L2_SCHED_FIXED_PRIORITY_EN
            exp = 2'd0;
`else
            exp = 2'(k % 3);
`endif
            #1;
            total++;
            if (req_ready3 !== (3'b001 << exp)) begin
                bad++; $display("FAIL p3_ready%0d got=%b need_port=%0d", k, req_ready3, exp);
            end
            adv();
            #1;
            total++;
            if (mem_id3[3:2] !== exp || mem_req_valid3 !== 1'b1) begin
                bad++;
                $display("FAIL p3_grant%0d got=%0d v=%b need=%0d", k, mem_id3[3:2],
                         mem_req_valid3, exp);
            end
            adv();
        end
        req_valid3 = 3'b000;
    endtask

    initial begin
        test_reset();
        test_two_reads();
        test_write_burst();
        test_stall();
        test_attr_full();
        test_reset_mid_burst();
        test_three_ports();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
